// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC register, req/ack instruction memory reader and valid/ready presenter.
// Define FETCH_PREFETCH_EN to add a one-entry prefetch buffer for 1 instruction/cycle throughput.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [25:0] jump_index
);
    typedef enum logic [1:0] {IDLE, FETCH, HOLD, DRAIN} state_t;

    state_t      state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic [31:0] last_pc4_reg, last_pc4_next;
    logic [31:0] instr_reg, instr_next;
    logic [31:0] pc_out_reg, pc_out_next;
    logic [31:0] drain_addr_reg, drain_addr_next;

    logic        redirect, transfer;
    logic [31:0] last_pc4_eff, target;

`ifdef FETCH_PREFETCH_EN
    logic        buf_valid_reg, buf_valid_next;
    logic [31:0] buf_data_reg, buf_data_next;
    logic [31:0] buf_pc_reg, buf_pc_next;
    logic        pf_req;
    assign pf_req = (state_reg == HOLD) && !buf_valid_reg;
`endif

    assign redirect     = branch_taken | jump;
    assign transfer     = (state_reg == HOLD) && instr_ready;
    // A jump accepted alongside a transfer forms its region from the word just delivered.
    assign last_pc4_eff = transfer ? (pc_out_reg + 32'd4) : last_pc4_reg;
    assign target       = branch_taken ? {branch_target[31:2], 2'b00}
                                       : {last_pc4_eff[31:28], jump_index, 2'b00};

`ifdef FETCH_PREFETCH_EN
    assign imem_req = (state_reg == FETCH) || (state_reg == DRAIN) || pf_req;
`else
    assign imem_req = (state_reg == FETCH) || (state_reg == DRAIN);
`endif
    assign imem_addr   = (state_reg == DRAIN) ? drain_addr_reg : pc_reg;
    assign instr       = instr_reg;
    assign opcode      = instr_reg[31:26];
    assign pc_out      = pc_out_reg;
    assign pc_plus4    = pc_out_reg + 32'd4;
    assign instr_valid = (state_reg == HOLD);

    always_comb begin
        state_next      = state_reg;
        pc_next         = pc_reg;
        last_pc4_next   = last_pc4_reg;
        instr_next      = instr_reg;
        pc_out_next     = pc_out_reg;
        drain_addr_next = drain_addr_reg;
`ifdef FETCH_PREFETCH_EN
        buf_valid_next  = buf_valid_reg;
        buf_data_next   = buf_data_reg;
        buf_pc_next     = buf_pc_reg;
`endif
        if (transfer)
            last_pc4_next = pc_out_reg + 32'd4;

        case (state_reg)
            IDLE: begin
                state_next = FETCH;
                if (redirect)
                    pc_next = target;
            end
            FETCH: begin
                if (redirect) begin
                    pc_next = target;
                    if (!imem_ack) begin
                        drain_addr_next = pc_reg;
                        state_next      = DRAIN;
                    end
                end else if (imem_ack) begin
                    instr_next  = imem_rdata;
                    pc_out_next = pc_reg;
                    pc_next     = pc_reg + 32'd4;
                    state_next  = HOLD;
                end
            end
            DRAIN: begin
                if (redirect)
                    pc_next = target;
                if (imem_ack)
                    state_next = FETCH;
            end
            HOLD: begin
`ifdef FETCH_PREFETCH_EN
                if (redirect) begin
                    pc_next        = target;
                    buf_valid_next = 1'b0;
                    if (pf_req && !imem_ack) begin
                        drain_addr_next = pc_reg;
                        state_next      = DRAIN;
                    end else begin
                        state_next = FETCH;
                    end
                end else if (transfer) begin
                    if (buf_valid_reg) begin
                        instr_next     = buf_data_reg;
                        pc_out_next    = buf_pc_reg;
                        buf_valid_next = 1'b0;
                    end else if (imem_ack) begin
                        instr_next  = imem_rdata;
                        pc_out_next = pc_reg;
                        pc_next     = pc_reg + 32'd4;
                    end else begin
                        // Prefetch still pending: FETCH keeps the same request alive.
                        state_next = FETCH;
                    end
                end else if (pf_req && imem_ack) begin
                    buf_valid_next = 1'b1;
                    buf_data_next  = imem_rdata;
                    buf_pc_next    = pc_reg;
                    pc_next        = pc_reg + 32'd4;
                end
`else
                if (redirect) begin
                    pc_next    = target;
                    state_next = FETCH;
                end else if (transfer) begin
                    state_next = FETCH;
                end
`endif
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            pc_reg         <= RESET_PC;
            last_pc4_reg   <= RESET_PC + 32'd4;
            instr_reg      <= 32'd0;
            pc_out_reg     <= RESET_PC;
            drain_addr_reg <= RESET_PC;
`ifdef FETCH_PREFETCH_EN
            buf_valid_reg  <= 1'b0;
            buf_data_reg   <= 32'd0;
            buf_pc_reg     <= RESET_PC;
`endif
        end else begin
            state_reg      <= state_next;
            pc_reg         <= pc_next;
            last_pc4_reg   <= last_pc4_next;
            instr_reg      <= instr_next;
            pc_out_reg     <= pc_out_next;
            drain_addr_reg <= drain_addr_next;
`ifdef FETCH_PREFETCH_EN
            buf_valid_reg  <= buf_valid_next;
            buf_data_reg   <= buf_data_next;
            buf_pc_reg     <= buf_pc_next;
`endif
        end
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit (default build); memory returns ~addr as the instruction word.
module tb_instr_fetch_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
    logic        instr_valid;
    logic        instr_ready;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [25:0] jump_index;

    logic zw;       // zero-wait: ack in the request cycle
    logic man_ack;  // manually driven ack when zw is low
    int   n_cmp = 0;
    int   n_err = 0;

    assign imem_ack   = imem_req & (zw | man_ack);
    assign imem_rdata = ~imem_addr;

    instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr(instr), .opcode(opcode), .pc_out(pc_out), .pc_plus4(pc_plus4),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .jump_index(jump_index)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        if (!rst && instr_valid && instr_ready)
            $display("xfer pc=%h instr=%h opcode=%h", pc_out, instr, opcode);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1; zw = 1; man_ack = 0; instr_ready = 0;
        branch_taken = 0; branch_target = 0; jump = 0; jump_index = 0;
        tick(); tick();
        n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL rst_req got %b want 0", imem_req); end
        n_cmp++; if (imem_addr !== 32'h0) begin n_err++; $display("FAIL rst_addr got %h want 0", imem_addr); end
        n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got %b want 0", instr_valid); end
        n_cmp++; if (instr !== 32'h0) begin n_err++; $display("FAIL rst_instr got %h want 0", instr); end
        n_cmp++; if (opcode !== 6'h0) begin n_err++; $display("FAIL rst_opcode got %h want 0", opcode); end
        n_cmp++; if (pc_out !== 32'h0) begin n_err++; $display("FAIL rst_pc_out got %h want 0", pc_out); end
        n_cmp++; if (pc_plus4 !== 32'h4) begin n_err++; $display("FAIL rst_pc_plus4 got %h want 4", pc_plus4); end
    endtask

    task automatic test_throughput();
        logic [31:0] exp_addr [3];
        logic [31:0] exp_word [3];
        exp_addr = '{32'h0, 32'h4, 32'h8};
        exp_word = '{32'hFFFF_FFFF, 32'hFFFF_FFFB, 32'hFFFF_FFF7};
        instr_ready = 1;
        rst = 0;
        n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL idle_req got %b want 0", imem_req); end
        tick();
        for (int k = 0; k < 3; k++) begin
            n_cmp++; if (imem_req !== 1'b1 || imem_addr !== exp_addr[k])
                begin n_err++; $display("FAIL tp_fetch%0d req=%b addr=%h want req=1 addr=%h", k, imem_req, imem_addr, exp_addr[k]); end
            n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL tp_gap%0d valid got %b want 0", k, instr_valid); end
            tick();
            n_cmp++; if (instr_valid !== 1'b1 || pc_out !== exp_addr[k] || instr !== exp_word[k])
                begin n_err++; $display("FAIL tp_hold%0d valid=%b pc=%h instr=%h want 1 %h %h", k, instr_valid, pc_out, instr, exp_addr[k], exp_word[k]); end
            n_cmp++; if (opcode !== 6'h3F) begin n_err++; $display("FAIL tp_opcode%0d got %h want 3f", k, opcode); end
            tick();
        end
    endtask

    task automatic test_wait_states();
        zw = 0; man_ack = 0;
        for (int w = 0; w < 4; w++) begin
            n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'hC || instr_valid !== 1'b0)
                begin n_err++; $display("FAIL wait%0d req=%b addr=%h valid=%b want 1 0000000c 0", w, imem_req, imem_addr, instr_valid); end
            if (w == 3) begin man_ack = 1; instr_ready = 0; end
            tick();
        end
        man_ack = 0;
        n_cmp++; if (instr_valid !== 1'b1 || instr !== 32'hFFFF_FFF3 || pc_out !== 32'hC)
            begin n_err++; $display("FAIL wait_resp valid=%b instr=%h pc=%h want 1 fffffff3 0000000c", instr_valid, instr, pc_out); end
    endtask

    task automatic test_ready_stall();
        for (int s = 0; s < 5; s++) begin
            n_cmp++; if (instr_valid !== 1'b1 || instr !== 32'hFFFF_FFF3 || pc_out !== 32'hC || imem_req !== 1'b0)
                begin n_err++; $display("FAIL stall%0d valid=%b instr=%h pc=%h req=%b want 1 fffffff3 0000000c 0", s, instr_valid, instr, pc_out, imem_req); end
            tick();
        end
        instr_ready = 1;
        tick();
        n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h10 || instr_valid !== 1'b0)
            begin n_err++; $display("FAIL stall_release req=%b addr=%h valid=%b want 1 00000010 0", imem_req, imem_addr, instr_valid); end
    endtask

    task automatic test_branch_drain();
        branch_taken = 1; branch_target = 32'h43;
        tick();
        branch_taken = 0;
        for (int d = 0; d < 2; d++) begin
            n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h10 || instr_valid !== 1'b0)
                begin n_err++; $display("FAIL drain%0d req=%b addr=%h valid=%b want 1 00000010 0", d, imem_req, imem_addr, instr_valid); end
            if (d == 1) man_ack = 1;
            tick();
        end
        man_ack = 0;
        n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h40 || instr_valid !== 1'b0)
            begin n_err++; $display("FAIL drain_target req=%b addr=%h valid=%b want 1 00000040 0", imem_req, imem_addr, instr_valid); end
        man_ack = 1;
        tick();
        man_ack = 0;
        n_cmp++; if (instr_valid !== 1'b1 || pc_out !== 32'h40 || instr !== 32'hFFFF_FFBF)
            begin n_err++; $display("FAIL branch_word valid=%b pc=%h instr=%h want 1 00000040 ffffffbf", instr_valid, pc_out, instr); end
    endtask

    task automatic test_jump();
        zw = 1; instr_ready = 0;
        branch_taken = 1; branch_target = 32'h1000_0004;
        tick();
        branch_taken = 0;
        n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h1000_0004 || instr_valid !== 1'b0)
            begin n_err++; $display("FAIL hold_redirect req=%b addr=%h valid=%b want 1 10000004 0", imem_req, imem_addr, instr_valid); end
        tick();
        n_cmp++; if (instr_valid !== 1'b1 || pc_out !== 32'h1000_0004)
            begin n_err++; $display("FAIL jump_pre valid=%b pc=%h want 1 10000004", instr_valid, pc_out); end
        instr_ready = 1; jump = 1; jump_index = 26'h10;
        tick();
        jump = 0;
        n_cmp++; if (imem_addr !== 32'h1000_0040 || instr_valid !== 1'b0)
            begin n_err++; $display("FAIL jump_addr addr=%h valid=%b want 10000040 0", imem_addr, instr_valid); end
        tick();
        n_cmp++; if (instr !== 32'hEFFF_FFBF || opcode !== 6'h3B || pc_plus4 !== 32'h1000_0044)
            begin n_err++; $display("FAIL jump_word instr=%h opcode=%h pc4=%h want efffffbf 3b 10000044", instr, opcode, pc_plus4); end
    endtask

    task automatic test_branch_priority();
        branch_taken = 1; branch_target = 32'h80; jump = 1; jump_index = 26'h20;
        tick();
        branch_taken = 0; jump = 0;
        n_cmp++; if (imem_addr !== 32'h80) begin n_err++; $display("FAIL prio_addr got %h want 00000080", imem_addr); end
        tick();
        n_cmp++; if (instr !== 32'hFFFF_FF7F || pc_out !== 32'h80)
            begin n_err++; $display("FAIL prio_word instr=%h pc=%h want ffffff7f 00000080", instr, pc_out); end
    endtask

    task automatic test_wrap();
        branch_taken = 1; branch_target = 32'hFFFF_FFFC;
        tick();
        branch_taken = 0;
        n_cmp++; if (imem_addr !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_fetch got %h want fffffffc", imem_addr); end
        tick();
        n_cmp++; if (pc_out !== 32'hFFFF_FFFC || pc_plus4 !== 32'h0 || instr !== 32'h3 || opcode !== 6'h0)
            begin n_err++; $display("FAIL wrap_word pc=%h pc4=%h instr=%h op=%h want fffffffc 0 3 0", pc_out, pc_plus4, instr, opcode); end
        tick();
        n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h0)
            begin n_err++; $display("FAIL wrap_next req=%b addr=%h want 1 00000000", imem_req, imem_addr); end
    endtask

    task automatic test_reset_in_drain();
        zw = 0; man_ack = 0;
        branch_taken = 1; branch_target = 32'h200;
        tick();
        branch_taken = 0;
        n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || instr_valid !== 1'b0)
            begin n_err++; $display("FAIL rd_drain req=%b addr=%h valid=%b want 1 0 0", imem_req, imem_addr, instr_valid); end
        rst = 1; man_ack = 1;
        tick();
        n_cmp++; if (imem_req !== 1'b0 || instr_valid !== 1'b0 || instr !== 32'h0 || pc_out !== 32'h0)
            begin n_err++; $display("FAIL rd_reset req=%b valid=%b instr=%h pc=%h want 0 0 0 0", imem_req, instr_valid, instr, pc_out); end
        rst = 0; man_ack = 0;
        tick();
        n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h0)
            begin n_err++; $display("FAIL rd_restart req=%b addr=%h want 1 00000000", imem_req, imem_addr); end
        man_ack = 1;
        tick();
        man_ack = 0;
        n_cmp++; if (instr_valid !== 1'b1 || pc_out !== 32'h0 || instr !== 32'hFFFF_FFFF)
            begin n_err++; $display("FAIL rd_word valid=%b pc=%h instr=%h want 1 0 ffffffff", instr_valid, pc_out, instr); end
    endtask

    initial begin
        test_reset();
        test_throughput();
        test_wait_states();
        test_ready_stall();
        test_branch_drain();
        test_jump();
        test_branch_priority();
        test_wrap();
        test_reset_in_drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch stage feeding the opcode decoder: holds the program counter, reads 32-bit instruction words from instruction memory over a request/acknowledge interface, and presents each word with a valid/ready handshake. `opcode` drives the control unit directly. Branch and jump redirects from downstream flush any held or in-flight fetch and restart at the new address.

## Interface
- `RESET_PC`, default 32'h0000_0000: byte address of the first fetch after reset; must be word-aligned.
- `clk`  in  1: the single clock; all logic is rising-edge.
- `rst`  in  1: reset, synchronous, active-high.
- `imem_req`  out  1: read request; once asserted, held with a stable `imem_addr` until `imem_ack`.
- `imem_addr`  out  32: word-aligned byte address; bits [1:0] are always 0.
- `imem_ack`  in  1: `imem_rdata` valid this cycle; may arrive in the request cycle or later.
- `imem_rdata`  in  32: instruction word.
- `instr`  out  32: presented instruction word.
- `opcode`  out  6: `instr[31:26]`.
- `pc_out`  out  32: address of `instr`.
- `pc_plus4`  out  32: `pc_out + 4`, modulo 2^32.
- `instr_valid`  out  1: `instr`, `opcode`, `pc_out` and `pc_plus4` are valid.
- `instr_ready`  in  1: downstream accepts; a transfer happens when valid and ready are both high.
- `branch_taken`  in  1: redirect to `branch_target`.
- `branch_target`  in  32: byte address; bits [1:0] are ignored and forced to 0.
- `jump`  in  1: redirect to {`last_pc4`[31:28], `jump_index`, 2'b00}.
- `jump_index`  in  26: jump word index.

## Operation
- Internal registers: `pc`, the next fetch address; `last_pc4`, the `pc_plus4` of the most recently accepted instruction (reset to `RESET_PC + 4`).
- States:
  - IDLE: the single cycle after reset.
  - FETCH: `imem_req` = 1, `imem_addr` = `pc`.
  - HOLD: `instr_valid` = 1.
  - DRAIN: the old request is still outstanding and its response will be discarded.
- Transitions:
  - IDLE -> FETCH unconditionally.
  - FETCH with `imem_ack`: latch `imem_rdata`, set `pc_out` = `pc`, set `pc` = `pc + 4`, go to HOLD.
  - HOLD on transfer: update `last_pc4`, go to FETCH.
  - HOLD without transfer: stay in HOLD; outputs are stable.
- Redirect (`branch_taken` or `jump` high for one cycle):
  - `branch_taken` has priority if both are high.
  - Target is loaded into `pc`.
  - From HOLD: drop the held word; go to FETCH. If a transfer occurs in the same cycle, the word is still delivered and `last_pc4` updates before the jump target is formed.
  - From FETCH with `imem_ack` that cycle: discard the data; go to FETCH at the target.
  - From FETCH without `imem_ack`: go to DRAIN. `imem_req` stays high at the old address until ack; that response is discarded; then go to FETCH at the target.
  - Redirect during DRAIN: only `pc` is updated; the latest target wins.
- Arithmetic: `pc` wraps from 32'hFFFF_FFFC to 0. No misalignment can occur.

## Timing
- Reset values:
  - `imem_req` 0, `imem_addr` `RESET_PC`.
  - `instr_valid` 0, `instr` 0, `opcode` 0.
  - `pc_out` `RESET_PC`, `pc_plus4` `RESET_PC + 4`.
  - State IDLE.
- First request: `imem_req` rises in the first cycle after `rst` falls.
- Fetch latency: ack in cycle N gives `instr_valid` = 1 in cycle N+1.
- Base throughput: one instruction per 2 cycles with a zero-wait memory.
- Redirect latency: redirect in cycle N gives `imem_req` at the target in cycle N+1 (FETCH and HOLD cases). `instr_valid` is 0 from N+1 until the target word returns.
- `rst` mid-operation: overrides everything next edge; any outstanding memory response is ignored.

## Configuration
- `FETCH_PREFETCH_EN` defined:
  - Adds a one-entry prefetch buffer.
  - In HOLD, `imem_req` stays asserted for `pc`. An acked word fills the buffer.
  - On transfer, the buffered word is presented in the next cycle, giving 1 instruction/cycle with a zero-wait memory.
  - A redirect flushes the buffer. An outstanding prefetch goes through DRAIN.
- Undefined: no buffer; `imem_req` = 0 in HOLD; behaviour as above.

## Test plan
- Reset release with `RESET_PC`=0, zero-wait memory, ready tied high -> `imem_addr` sequence 0, 4, 8; `instr_valid` every other cycle (every cycle with `FETCH_PREFETCH_EN`); `opcode` = `rdata[31:26]`.
- Memory acks after 3 wait cycles -> `imem_addr` held stable for 4 cycles; `instr_valid` the cycle after ack.
- `instr_ready` low for 5 cycles in HOLD -> `instr`/`pc_out` stable, no new request (base build).
- `branch_taken` with target 32'h40 while a fetch of 0x8 is waiting on ack -> DRAIN; the 0x8 word is never presented; next `imem_addr` = 0x40.
- `jump` with `jump_index` = 26'h10, `last_pc4` = 32'h1000_0008 -> next fetch 32'h1000_0040. Branch and jump together -> branch target wins.
- `pc` = 32'hFFFF_FFFC fetched -> next `imem_addr` = 0; `pc_plus4` = 0. `rst` pulsed during DRAIN -> `instr_valid` 0 and fetch restarts at `RESET_PC`.
